spi_master_32bit: RTL

Mode-0 SPI controller that drives one 32-bit full-duplex frame to the gimbal SPI slave. Each frame sends `{pitch_pwm, yaw_pwm}` on PICO and captures `{pitch_data, yaw_data}` from POCI. Both directions are MSB first. It is the host-side counterpart of `SPI_Slave` and runs in the 100 MHz system clock domain. It generates SPI_CLK from a programmable divider.

---
 rtl/spi_master_32bit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spi_master_32bit.sv
// Mode-0 SPI master: one 32-bit full-duplex frame, {pitch, yaw} out on PICO,
// {pitch, yaw} captured from POCI, MSB first, SPI_CLK from a programmable divider.
`timescale 1ns/1ps
module spi_master_32bit #(
   parameter int unsigned CLK_DIV = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] pitch_pwm_in,
   input  logic [15:0] yaw_pwm_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] pitch_data_out,
   output logic [15:0] yaw_data_out,
   output logic        SPI_CLK,
   output logic        SPI_CS,
   output logic        SPI_PICO,
   input  logic        SPI_POCI
);

   localparam int unsigned FRAME_W = 32;
   localparam int unsigned HALF_W  = 16;
   localparam int unsigned BIT_W   = 5;
   localparam int unsigned DIV_W   = $clog2(2*CLK_DIV+1);
   localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV-1);
   localparam logic [DIV_W-1:0] HOLD_LAST  = DIV_W'(2*CLK_DIV-1);

   typedef enum logic [2:0] {IDLE, SETUP, SCK_HIGH, SCK_LOW, HOLD, GAP} state_t;

   state_t               state;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   // Holds only the bits not yet driven; bit 31 goes straight to PICO at accept.
   logic [FRAME_W-2:0]   tx_sr;
   logic [FRAME_W-1:0]   rx_sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         div_cnt        <= '0;
         bit_cnt        <= '0;
         tx_sr          <= '0;
         rx_sr          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pitch_data_out <= '0;
         yaw_data_out   <= '0;
         SPI_CLK        <= 1'b0;
         SPI_CS         <= 1'b1;
         SPI_PICO       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_sr    <= {pitch_pwm_in[HALF_W-2:0], yaw_pwm_in};
                  bit_cnt  <= BIT_W'(FRAME_W-1);
                  div_cnt  <= '0;
                  SPI_CS   <= 1'b0;
                  SPI_PICO <= pitch_pwm_in[HALF_W-1];
                  busy     <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP, SCK_LOW: begin
               if (div_cnt == PHASE_LAST) begin
                  div_cnt <= '0;
                  SPI_CLK <= 1'b1;
                  rx_sr   <= {rx_sr[FRAME_W-2:0], SPI_POCI};
                  state   <= SCK_HIGH;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            SCK_HIGH: begin
               if (div_cnt == PHASE_LAST) begin
                  div_cnt <= '0;
                  SPI_CLK <= 1'b0;
                  // The 32nd falling edge starts the CS hold directly.
                  if (bit_cnt == '0) begin
                     state <= HOLD;
                  end else begin
                     SPI_PICO <= tx_sr[FRAME_W-2];
                     tx_sr    <= {tx_sr[FRAME_W-3:0], 1'b0};
                     bit_cnt  <= bit_cnt - BIT_W'(1);
                     state    <= SCK_LOW;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            HOLD: begin
               if (div_cnt == HOLD_LAST) begin
                  div_cnt        <= '0;
                  SPI_CS         <= 1'b1;
                  SPI_PICO       <= 1'b0;
                  pitch_data_out <= rx_sr[FRAME_W-1:HALF_W];
                  yaw_data_out   <= rx_sr[HALF_W-1:0];
                  done           <= 1'b1;
                  state          <= GAP;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            GAP: begin
               if (div_cnt == PHASE_LAST) begin
                  div_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
